// File: rtl/result_monitor_pkg.sv
// result_monitor_pkg: shared FSM states, golden-op encodings and the latency sentinel
package result_monitor_pkg;
  localparam logic [1:0] ST_WAIT  = 2'b00;
  localparam logic [1:0] ST_FLUSH = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam logic [31:0] NOT_MEASURED = 32'h0000FFFF;
endpackage

// File: rtl/operand_delay_line.sv
// operand_delay_line: free-running {a,b} shift register with a selectable tap
// Ports: clk_dut/reset (async, active-high); i_a/i_b operands; i_sel tap index
// (0 = current inputs, k = operands from k cycles ago); o_a/o_b selected tap.
module operand_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SW-1:0]    i_sel,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);
  logic [DEPTH-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DEPTH:0][WIDTH-1:0] a_t, b_t;
  // a_t[0] is the live input, a_t[k] the register holding tap k
  always_comb begin
    a_t = {a_q, i_a};
    b_t = {b_q, i_b};
    a_d = a_t[DEPTH-1:0];
    b_d = b_t[DEPTH-1:0];
  end
  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign o_a = a_t[i_sel];
  assign o_b = b_t[i_sel];
endmodule

// File: rtl/result_monitor.sv
// result_monitor: realigns operands with DUT results, checks a golden op, keeps stats
// Ports: clk_dut/reset (async, active-high); i_drive_a/b operands sent to the DUT;
// i_dut_out DUT result; i_dut_delay measured latency (0xFFFF = not measured);
// o_state FSM state; o_test_count/o_err_count statistics; o_first_* first failing
// vector; o_done run finished; o_pass no errors; o_fault latency beyond MAX_DELAY.
module result_monitor
  import result_monitor_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          MAX_DELAY = 16,
  parameter logic [31:0] N_TESTS   = 32'd65536,
  parameter int          OP        = 0
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_drive_a,
  input  logic [WIDTH-1:0] i_drive_b,
  input  logic [WIDTH-1:0] i_dut_out,
  input  logic [31:0]      i_dut_delay,
  output logic [1:0]       o_state,
  output logic [31:0]      o_test_count,
  output logic [31:0]      o_err_count,
  output logic [WIDTH-1:0] o_first_a,
  output logic [WIDTH-1:0] o_first_b,
  output logic [WIDTH-1:0] o_first_out,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_fault
);
  localparam int SW = $clog2(MAX_DELAY + 1);
  logic [1:0] state_q, state_d;
  logic [SW-1:0] lat_q, lat_d, flush_q, flush_d;
  logic [31:0] test_count_q, test_count_d, err_count_q, err_count_d;
  logic [WIDTH-1:0] first_a_q, first_a_d, first_b_q, first_b_d, first_out_q, first_out_d;
  logic fault_q, fault_d;
  logic [WIDTH-1:0] tap_a, tap_b, exp_val;
  logic mismatch;
  operand_delay_line #(.WIDTH(WIDTH), .DEPTH(MAX_DELAY)) u_delay (
    .clk_dut(clk_dut),
    .reset  (reset),
    .i_a    (i_drive_a),
    .i_b    (i_drive_b),
    .i_sel  (lat_q),
    .o_a    (tap_a),
    .o_b    (tap_b)
  );
  always_comb begin
    exp_val  = OP == OP_SUB ? tap_a - tap_b : OP == OP_MUL ? tap_a * tap_b : tap_a + tap_b;
    mismatch = exp_val != i_dut_out;
  end
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    flush_d      = flush_q;
    test_count_d = test_count_q;
    err_count_d  = err_count_q;
    first_a_d    = first_a_q;
    first_b_d    = first_b_q;
    first_out_d  = first_out_q;
    fault_d      = fault_q;
    case (state_q)
      ST_WAIT: if (i_dut_delay != NOT_MEASURED) begin
        if (i_dut_delay > 32'(MAX_DELAY)) begin
          fault_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          lat_d   = i_dut_delay[SW-1:0];
          flush_d = '0;
          state_d = ST_FLUSH;
        end
      end
      // lat+1 cycles guarantees tap[lat] was written after the latch
      ST_FLUSH: begin
        flush_d = flush_q + 1'b1;
        state_d = flush_q == lat_q ? ST_RUN : ST_FLUSH;
      end
      ST_RUN: begin
        test_count_d = test_count_q + 32'd1;
        if (mismatch) begin
          err_count_d = &err_count_q ? err_count_q : err_count_q + 32'd1;
          if (err_count_q == '0) begin
            first_a_d   = tap_a;
            first_b_d   = tap_b;
            first_out_d = i_dut_out;
          end
        end
        state_d = test_count_q == N_TESTS - 32'd1 ? ST_DONE : ST_RUN;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT;
      lat_q        <= '0;
      flush_q      <= '0;
      test_count_q <= '0;
      err_count_q  <= '0;
      first_a_q    <= '0;
      first_b_q    <= '0;
      first_out_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      flush_q      <= flush_d;
      test_count_q <= test_count_d;
      err_count_q  <= err_count_d;
      first_a_q    <= first_a_d;
      first_b_q    <= first_b_d;
      first_out_q  <= first_out_d;
      fault_q      <= fault_d;
    end
  end
  assign o_state      = state_q;
  assign o_test_count = test_count_q;
  assign o_err_count  = err_count_q;
  assign o_first_a    = first_a_q;
  assign o_first_b    = first_b_q;
  assign o_first_out  = first_out_q;
  assign o_fault      = fault_q;
  assign o_done       = state_q == ST_DONE;
  assign o_pass       = o_done & ~fault_q & (err_count_q == '0);
endmodule

// File: doc/result_monitor.md
# result_monitor

Receiving end of the arithmetic stimulus path. The driver measures DUT latency and publishes it as `o_dut_delay`; this block takes that latency and re-aligns the operands that were sent to the DUT with the DUT result. It checks each result against a golden model and accumulates pass/fail statistics, and it captures the first failing vector for readback over the board debug path.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `MAX_DELAY`, 16: depth of the operand delay line, i.e. the largest DUT latency that can be checked.
- `N_TESTS`, 32'd65536: number of compared vectors before the block reports done.
- `OP`, 0: golden operation. 0 = a+b, 1 = a−b, 2 = a*b low `WIDTH` bits. All arithmetic is modulo 2^WIDTH.

Ports:
- `clk_dut`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `i_drive_a`, in, WIDTH: operand A as presented to the DUT this cycle.
- `i_drive_b`, in, WIDTH: operand B as presented to the DUT this cycle.
- `i_dut_out`, in, WIDTH: DUT result.
- `i_dut_delay`, in, 32: measured DUT latency. The value 32'h0000FFFF means not yet measured.
- `o_state`, out, 2: current FSM state.
- `o_test_count`, out, 32: number of vectors compared.
- `o_err_count`, out, 32: number of mismatches; saturates at 32'hFFFFFFFF.
- `o_first_a`, out, WIDTH: operand A of the first failing vector.
- `o_first_b`, out, WIDTH: operand B of the first failing vector.
- `o_first_out`, out, WIDTH: DUT result of the first failing vector.
- `o_done`, out, 1: test run finished.
- `o_pass`, out, 1: valid only when `o_done`=1; high when zero errors were seen.
- `o_fault`, out, 1: measured latency is larger than `MAX_DELAY`.

## Operation
- **Delay line.** Taps 1..MAX_DELAY hold `{a,b}` shifted every cycle, free-running from reset.
  - Tap k holds the operands driven k cycles earlier.
  - Tap 0 is the current `i_drive_a` and `i_drive_b`, taken combinationally.
- **Latency latch.** Register `lat` captures `i_dut_delay` on the WAIT→FLUSH transition.
  - The aligned operands are tap[`lat`].
  - Later changes on `i_dut_delay` are ignored until reset.
- **Golden model.** `exp = OP(tap_a[lat], tap_b[lat])`, computed combinationally. A mismatch is `exp != i_dut_out`.
- **FSM**, encoded as WAIT=2'b00, FLUSH=2'b01, RUN=2'b10, DONE=2'b11:
  - WAIT:
    - If `i_dut_delay` is 0x0000FFFF, stay in WAIT.
    - Else if `i_dut_delay` > MAX_DELAY: set `o_fault`, go to DONE with `o_pass`=0.
    - Else latch `lat`, clear the flush counter, go to FLUSH.
  - FLUSH: count `lat`+1 cycles, then go to RUN. This guarantees the selected tap holds post-latch data.
  - RUN, each cycle:
    - `test_count` +1.
    - On mismatch, `err_count` +1 (saturating).
    - If this is the first mismatch, load `o_first_*` from tap[`lat`] and `i_dut_out`.
    - When `test_count` reaches N_TESTS−1 in this cycle, the next state is DONE. Exactly N_TESTS compares are made.
  - DONE: terminal. All counters frozen. Leaves only on reset.
- **Output assignments.** `o_done` = (state==DONE). `o_pass` = `o_done` & !`o_fault` & (`err_count`==0).
- **Reset**, asserted at any time including mid-RUN, clears everything:
  - state → WAIT.
  - Counters, `lat`, `o_first_*` and `o_fault` → 0.
  - The delay line is cleared to 0.

## Timing
- Reset values: `o_state`=0; `o_test_count`=0; `o_err_count`=0; `o_first_*`=0; `o_done`=0; `o_pass`=0; `o_fault`=0.
- All outputs are registered except `o_done` and `o_pass`, which decode registered state.
- WAIT→FLUSH takes 1 cycle after `i_dut_delay` becomes valid. FLUSH lasts `lat`+1 cycles.
- The compare result is visible in the counters 1 cycle after the compared edge.
- `lat`=0 is legal and compares the current inputs against the same-cycle `i_dut_out`.
- First-error capture and its error-count increment happen in the same cycle.
- Once `err_count` saturates, `o_first_*` remain unchanged.

## Structure
- A shared package holds:
  - FSM state constants.
  - OP encodings.
  - The not-measured constant 32'h0000FFFF.
- One sub-module, `operand_delay_line`: parameterised depth, a tap-select input, and a registered shift of `{a,b}` with asynchronous clear. The top level keeps the FSM, golden model and counters.

## Test plan
- Ideal adder DUT with 3-cycle pipeline, `i_dut_delay`=3 after 100 cycles:
  - Pass through FLUSH (4 cycles), then RUN.
  - After N_TESTS=1000 (overridden), `o_done`=1, `o_pass`=1, `o_test_count`=1000, `o_err_count`=0.
- Same DUT, forcing `i_dut_out` to 32'h0 once with operands a=32'h00000005, b=32'h00000007:
  - `o_err_count`=1.
  - `o_first_a`=5, `o_first_b`=7, `o_first_out`=0.
  - `o_pass`=0.
- Combinational subtractor (OP=1), `i_dut_delay`=0, a=0, b=1:
  - Result 32'hFFFFFFFF matches the golden value (wrap-around).
  - Zero errors.
- `i_dut_delay`=17 with MAX_DELAY=16: next cycle `o_fault`=1, `o_state`=2'b11, `o_pass`=0, `o_test_count`=0.
- Reset asserted mid-RUN at `test_count`=500:
  - All outputs return to 0 and `o_state`=WAIT.
  - After release, with `i_dut_delay` still valid, the block re-enters FLUSH and then RUN, and counts from 0.
- Always-wrong DUT with `err_count` preloaded near saturation (via force): the counter holds at 32'hFFFFFFFF and does not wrap.
